// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: configuration sequencer for the PLL.
// Accepts divider settings over valid/ready and rejects out-of-range ratios.
// It then holds the PLL in reset for a fixed time and waits for a stable,
// synchronised lock under a timeout. Status goes back to the CSR front-end.
// Optional build macro: PLL_CFG_CTRL_AUTO_RELOCK_EN. When it is defined, a
// loss of lock re-runs the reset/lock sequence with the same dividers instead
// of parking in S_ERROR.
//
// state        | meaning
// S_IDLE       | out of reset, PLL held in reset, waiting for first config
// S_RESET      | pll_arst_no low, counting RST_CYCLES
// S_WAIT_LOCK  | PLL released, counting stable lock cycles and timeout
// S_LOCKED     | lock declared, watching for loss of lock
// S_ERROR      | timeout or lost lock, waiting for a new config
module pll_cfg_ctrl #(
    parameter int REF_DIV_WIDTH = 8,
    parameter int FB_DIV_WIDTH  = 12,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_STABLE   = 8,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [REF_DIV_WIDTH-1:0] cfg_ref_div_i,
    input  logic [FB_DIV_WIDTH-1:0]  cfg_fb_div_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    output logic                     pll_arst_no,
    output logic [REF_DIV_WIDTH-1:0] pll_ref_div_o,
    output logic [FB_DIV_WIDTH-1:0]  pll_fb_div_o,
    input  logic                     pll_locked_i,
    output logic                     busy_o,
    output logic                     locked_o,
    output logic                     err_cfg_o,
    output logic                     err_timeout_o,
    output logic                     err_lost_o
);
    // Ratio check width: the wider divider plus headroom for the x100 product.
    localparam int VAL_W = ((REF_DIV_WIDTH > FB_DIV_WIDTH) ? REF_DIV_WIDTH : FB_DIV_WIDTH) + 7;
    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE);
    localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_LOCKED    = 3'd3,
        S_ERROR     = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     lock_s1_q, lock_s2_q;
    logic                     arst_n_q, arst_n_d;
    logic [REF_DIV_WIDTH-1:0] ref_q, ref_d;
    logic [FB_DIV_WIDTH-1:0]  fb_q, fb_d;
    logic                     err_cfg_q, err_cfg_d;
    logic                     err_tmo_q, err_tmo_d;
    logic                     err_lost_q, err_lost_d;
    logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]         stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic                     lock_sync;
    logic [STB_W-1:0]         stb_nxt;
    logic [TMO_W-1:0]         tmo_nxt;
    logic [VAL_W-1:0]         ref_ext, fb_ext, ref_x100, fb_x100;
    logic                     cfg_ok;
    logic                     cfg_accept;

    assign lock_sync = lock_s2_q;

    assign ref_ext  = VAL_W'(cfg_ref_div_i);
    assign fb_ext   = VAL_W'(cfg_fb_div_i);
    assign ref_x100 = ref_ext * VAL_W'(100);
    assign fb_x100  = fb_ext * VAL_W'(100);
    assign cfg_ok   = (ref_ext != '0) && (fb_ext != '0) &&
                      (ref_ext <= fb_x100) && (ref_x100 >= fb_ext);

    assign cfg_ready_o = (state_q == S_IDLE) || (state_q == S_LOCKED) || (state_q == S_ERROR);
    assign cfg_accept  = cfg_valid_i && cfg_ready_o;
    assign busy_o      = (state_q == S_RESET) || (state_q == S_WAIT_LOCK);
    assign locked_o    = (state_q == S_LOCKED);

    assign pll_arst_no   = arst_n_q;
    assign pll_ref_div_o = ref_q;
    assign pll_fb_div_o  = fb_q;
    assign err_cfg_o     = err_cfg_q;
    assign err_timeout_o = err_tmo_q;
    assign err_lost_o    = err_lost_q;

    // A dropout restarts the stable run; both counters saturate.
    assign stb_nxt = !lock_sync ? '0 :
                     (stb_cnt_q == STB_DONE) ? stb_cnt_q : stb_cnt_q + 1'b1;
    assign tmo_nxt = (tmo_cnt_q == TMO_DONE) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d    = state_q;
        arst_n_d   = arst_n_q;
        ref_d      = ref_q;
        fb_d       = fb_q;
        err_cfg_d  = 1'b0;
        err_tmo_d  = err_tmo_q;
        err_lost_d = err_lost_q;
        rst_cnt_d  = rst_cnt_q;
        stb_cnt_d  = stb_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    arst_n_d  = 1'b1;
                    stb_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                stb_cnt_d = stb_nxt;
                tmo_cnt_d = tmo_nxt;
                // A stable run that completes on the timeout cycle still counts as lock.
                if (stb_nxt == STB_DONE) begin
                    state_d = S_LOCKED;
                end else if (tmo_nxt == TMO_DONE) begin
                    state_d   = S_ERROR;
                    err_tmo_d = 1'b1;
                end
            end
            S_LOCKED: begin
                if (!lock_sync) begin
                    err_lost_d = 1'b1;
`ifdef PLL_CFG_CTRL_AUTO_RELOCK_EN
                    state_d   = S_RESET;
                    arst_n_d  = 1'b0;
                    rst_cnt_d = '0;
`else
                    state_d = S_ERROR;
`endif
                end
            end
            default: ;
        endcase

        // An accepted config overrides any loss-of-lock decision on the same cycle.
        if (cfg_accept) begin
            if (cfg_ok) begin
                state_d    = S_RESET;
                ref_d      = cfg_ref_div_i;
                fb_d       = cfg_fb_div_i;
                arst_n_d   = 1'b0;
                err_tmo_d  = 1'b0;
                err_lost_d = 1'b0;
                rst_cnt_d  = '0;
            end else begin
                err_cfg_d = 1'b1;
            end
        end
    end

    // State, outputs, counters and the lock synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
            arst_n_q   <= 1'b0;
            ref_q      <= REF_DIV_WIDTH'(1);
            fb_q       <= FB_DIV_WIDTH'(1);
            err_cfg_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_lost_q <= 1'b0;
            rst_cnt_q  <= '0;
            stb_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_s1_q  <= pll_locked_i;
            lock_s2_q  <= lock_s1_q;
            arst_n_q   <= arst_n_d;
            ref_q      <= ref_d;
            fb_q       <= fb_d;
            err_cfg_q  <= err_cfg_d;
            err_tmo_q  <= err_tmo_d;
            err_lost_q <= err_lost_d;
            rst_cnt_q  <= rst_cnt_d;
            stb_cnt_q  <= stb_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: directed and randomised bench for pll_cfg_ctrl.
// Expected lock/timeout edges come from the raw lock pattern. A raw value
// driven in the cycle after edge k reaches the lock decision at edge k+3.
module tb_pll_cfg_ctrl;
    localparam int REF_W        = 8;
    localparam int FB_W         = 12;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 4096;
    localparam int PAT_LEN      = 4300;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [REF_W-1:0] cfg_ref_div_i;
    logic [FB_W-1:0]  cfg_fb_div_i;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic             pll_arst_no;
    logic [REF_W-1:0] pll_ref_div_o;
    logic [FB_W-1:0]  pll_fb_div_o;
    logic             pll_locked_i;
    logic             busy_o;
    logic             locked_o;
    logic             err_cfg_o;
    logic             err_timeout_o;
    logic             err_lost_o;

    int checks   = 0;
    int failures = 0;
    bit raw_pat [PAT_LEN];
    bit pre_val;
    int cur_ref;
    int cur_fb;
    bit cur_locked;

    pll_cfg_ctrl #(
        .REF_DIV_WIDTH(REF_W),
        .FB_DIV_WIDTH (FB_W),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_ref_div_i(cfg_ref_div_i),
        .cfg_fb_div_i (cfg_fb_div_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .pll_arst_no  (pll_arst_no),
        .pll_ref_div_o(pll_ref_div_o),
        .pll_fb_div_o (pll_fb_div_o),
        .pll_locked_i (pll_locked_i),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .err_cfg_o    (err_cfg_o),
        .err_timeout_o(err_timeout_o),
        .err_lost_o   (err_lost_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic bit model_cfg_ok(input int r, input int f);
        return (r > 0) && (f > 0) && (r <= 100 * f) && (100 * r >= f);
    endfunction

    // First edge after release with LOCK_STABLE consecutive high raw values
    // ending 3 cycles earlier; 0 means the timeout wins.
    function automatic int model_lock_edge();
        for (int j = LOCK_STABLE; j <= LOCK_TIMEOUT; j++) begin
            bit ok;
            ok = 1'b1;
            for (int n = 0; n < LOCK_STABLE; n++) begin
                int idx;
                idx = j - 3 - n;
                if (idx < 0) begin
                    if (!pre_val) ok = 1'b0;
                end else if (!raw_pat[idx]) begin
                    ok = 1'b0;
                end
            end
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  32'(cfg_ready_o), 1);
        check({tag, "_arst_n"}, 32'(pll_arst_no), 0);
        check({tag, "_ref"},    32'(pll_ref_div_o), 1);
        check({tag, "_fb"},     32'(pll_fb_div_o), 1);
        check({tag, "_busy"},   32'(busy_o), 0);
        check({tag, "_locked"}, 32'(locked_o), 0);
        check({tag, "_ecfg"},   32'(err_cfg_o), 0);
        check({tag, "_etmo"},   32'(err_timeout_o), 0);
        check({tag, "_elost"},  32'(err_lost_o), 0);
    endtask

    task automatic fill_pat_from(input int start);
        for (int k = 0; k < PAT_LEN; k++) raw_pat[k] = (k >= start);
    endtask

    task automatic start_cfg(input string tag, input int r, input int f);
        int n;
        cfg_ref_div_i = REF_W'(r);
        cfg_fb_div_i  = FB_W'(f);
        cfg_valid_i   = 1'b1;
        tick();
        cfg_valid_i  = 1'b0;
        pll_locked_i = pre_val;
        check({tag, "_acc_arst_n"}, 32'(pll_arst_no), 0);
        check({tag, "_acc_busy"},   32'(busy_o), 1);
        check({tag, "_acc_ready"},  32'(cfg_ready_o), 0);
        check({tag, "_acc_locked"}, 32'(locked_o), 0);
        check({tag, "_acc_ref"},    32'(pll_ref_div_o), r);
        check({tag, "_acc_fb"},     32'(pll_fb_div_o), f);
        check({tag, "_acc_etmo"},   32'(err_timeout_o), 0);
        check({tag, "_acc_elost"},  32'(err_lost_o), 0);
        n = 0;
        while (pll_arst_no == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_rst_len"}, 32'(n), RST_CYCLES);
        cur_ref = r;
        cur_fb  = f;
    endtask

    task automatic run_wait(input string tag);
        int m;
        int lock_j;
        int tmo_j;
        m      = model_lock_edge();
        lock_j = 0;
        tmo_j  = 0;
        for (int k = 0; k < PAT_LEN; k++) begin
            pll_locked_i = raw_pat[k];
            tick();
            if (locked_o) begin
                lock_j = k + 1;
                break;
            end
            if (err_timeout_o) begin
                tmo_j = k + 1;
                break;
            end
        end
        if (m > 0) pll_locked_i = 1'b1;
        cur_locked = (m > 0);
        check({tag, "_lock_edge"}, 32'(lock_j), m);
        check({tag, "_tmo_edge"},  32'(tmo_j), (m > 0) ? 0 : LOCK_TIMEOUT);
        check({tag, "_locked"},    32'(locked_o), (m > 0) ? 1 : 0);
        check({tag, "_etmo"},      32'(err_timeout_o), (m > 0) ? 0 : 1);
        check({tag, "_busy"},      32'(busy_o), 0);
        check({tag, "_ready"},     32'(cfg_ready_o), 1);
        check({tag, "_arst_n"},    32'(pll_arst_no), 1);
    endtask

    task automatic bad_cfg(input string tag, input int r, input int f);
        cfg_ref_div_i = REF_W'(r);
        cfg_fb_div_i  = FB_W'(f);
        cfg_valid_i   = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        check({tag, "_ecfg"},   32'(err_cfg_o), 1);
        check({tag, "_locked"}, 32'(locked_o), 32'(cur_locked));
        check({tag, "_ref"},    32'(pll_ref_div_o), cur_ref);
        check({tag, "_fb"},     32'(pll_fb_div_o), cur_fb);
        check({tag, "_arst_n"}, 32'(pll_arst_no), 1);
        check({tag, "_busy"},   32'(busy_o), 0);
        tick();
        check({tag, "_ecfg_end"},   32'(err_cfg_o), 0);
        check({tag, "_locked_end"}, 32'(locked_o), 32'(cur_locked));
    endtask

    initial begin
        int n;
        rst_i         = 1'b1;
        cfg_valid_i   = 1'b0;
        cfg_ref_div_i = '0;
        cfg_fb_div_i  = '0;
        pll_locked_i  = 1'b0;
        pre_val       = 1'b0;
        cur_ref       = 1;
        cur_fb        = 1;
        cur_locked    = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst_i = 1'b0;
        tick();
        check_reset_vals("idle");

        // Basic bring-up: lock appears 40 cycles after release.
        pre_val = 1'b0;
        fill_pat_from(40);
        start_cfg("t1", 1, 10);
        run_wait("t1");

        // Rejected requests leave the locked PLL untouched.
        bad_cfg("t2_ref0", 0, 5);
        bad_cfg("t2_ratio", 1, 101);

        // Lock high 5, low 1, then steady: the stable run must restart.
        pre_val = 1'b0;
        fill_pat_from(30);
        raw_pat[35] = 1'b0;
        start_cfg("t4", 2, 50);
        run_wait("t4");

        // One-cycle loss of lock while locked.
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        n = 1;
        while (!err_lost_o && n < 20) begin
            tick();
            n++;
        end
        check("t5_lost_latency", 32'(n), 3);
        check("t5_elost", 32'(err_lost_o), 1);
`ifdef PLL_CFG_CTRL_AUTO_RELOCK_EN
        check("t5_arst_n", 32'(pll_arst_no), 0);
        check("t5_busy",   32'(busy_o), 1);
        check("t5_locked", 32'(locked_o), 0);
        n = 0;
        while (pll_arst_no == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("t5_rst_len", 32'(n), RST_CYCLES);
        pre_val = 1'b1;
        fill_pat_from(0);
        run_wait("t5_relock");
        check("t5_elost_hold", 32'(err_lost_o), 1);
        check("t5_ref", 32'(pll_ref_div_o), cur_ref);
        check("t5_fb",  32'(pll_fb_div_o), cur_fb);
`else
        check("t5_locked", 32'(locked_o), 0);
        check("t5_busy",   32'(busy_o), 0);
        check("t5_ready",  32'(cfg_ready_o), 1);
        check("t5_arst_n", 32'(pll_arst_no), 1);
        repeat (5) tick();
        check("t5_err_hold_locked", 32'(locked_o), 0);
        check("t5_err_hold_arst",   32'(pll_arst_no), 1);
        check("t5_err_hold_ref",    32'(pll_ref_div_o), cur_ref);
        check("t5_err_hold_fb",     32'(pll_fb_div_o), cur_fb);
        cur_locked = 1'b0;
`endif

        // Lock never arrives: timeout at exactly LOCK_TIMEOUT cycles.
        pre_val = 1'b0;
        fill_pat_from(PAT_LEN);
        start_cfg("t3", 4, 300);
        run_wait("t3");

        // Stable run completing on the timeout cycle: lock must win.
        pre_val = 1'b0;
        fill_pat_from(LOCK_TIMEOUT - 3 - (LOCK_STABLE - 1));
        start_cfg("tb", 5, 7);
        run_wait("tb");

        // Randomised requests: boundary ratios, zeros and random lock prefixes.
        for (int it = 0; it < 12; it++) begin
            int r;
            int f;
            int kind;
            int start;
            kind = $urandom_range(0, 6);
            case (kind)
                0: begin r = 0; f = $urandom_range(1, 4095); end
                1: begin r = $urandom_range(1, 40); f = 100 * r + 1 + $urandom_range(0, 50); end
                2: begin f = $urandom_range(1, 2); r = 100 * f + 1 + $urandom_range(0, 50); end
                3: begin r = $urandom_range(1, 40); f = 100 * r; end
                4: begin f = $urandom_range(1, 2); r = 100 * f; end
                5: begin r = $urandom_range(1, 255); f = $urandom_range(1, 4095); end
                default: begin r = $urandom_range(1, 255); f = 0; end
            endcase
            if (model_cfg_ok(r, f)) begin
                pre_val = 1'($urandom_range(0, 1));
                start   = $urandom_range(0, 150);
                for (int k = 0; k < PAT_LEN; k++) begin
                    if (k >= start) raw_pat[k] = 1'b1;
                    else if (k % 7 == 5) raw_pat[k] = 1'b0;
                    else raw_pat[k] = 1'($urandom_range(0, 1));
                end
                start_cfg($sformatf("rnd%0d", it), r, f);
                run_wait($sformatf("rnd%0d", it));
            end else begin
                bad_cfg($sformatf("rnd%0d_bad", it), r, f);
            end
        end

        // Synchronous reset in the middle of WAIT_LOCK.
        pre_val = 1'b0;
        start_cfg("t6", 3, 30);
        pll_locked_i = 1'b0;
        repeat (20) tick();
        check("t6_busy_pre", 32'(busy_o), 1);
        rst_i = 1'b1;
        tick();
        check_reset_vals("t6_rst");
        rst_i = 1'b0;
        tick();
        check_reset_vals("t6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_cfg_ctrl.md
Name: pll_cfg_ctrl

Overview:
Configuration sequencer for the pll block. It accepts divider settings over a valid/ready handshake and validates them. It then drives the PLL reset and divider inputs, waits for a stable lock with a timeout, and reports status. The block sits in the system clock domain between a register/CSR front-end and the pll instance.

Parameters:
REF_DIV_WIDTH, 8, width of the reference divider
FB_DIV_WIDTH, 12, width of the feedback divider
RST_CYCLES, 16, number of clk_i cycles pll_arst_no is held low per configuration (must be >=1)
LOCK_STABLE, 8, consecutive synchronised lock-high cycles required to declare lock (must be >=1)
LOCK_TIMEOUT, 4096, maximum clk_i cycles in WAIT_LOCK before a timeout error

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
cfg_ref_div_i  in  REF_DIV_WIDTH  requested reference divider
cfg_fb_div_i  in  FB_DIV_WIDTH  requested feedback divider
cfg_valid_i  in  1  configuration request valid
cfg_ready_o  out  1  controller can accept a configuration
pll_arst_no  out  1  active-low reset to the PLL
pll_ref_div_o  out  REF_DIV_WIDTH  reference divider driven to the PLL
pll_fb_div_o  out  FB_DIV_WIDTH  feedback divider driven to the PLL
pll_locked_i  in  1  raw PLL lock, asynchronous to clk_i
busy_o  out  1  high in RESET and WAIT_LOCK
locked_o  out  1  high only in LOCKED
err_cfg_o  out  1  one-cycle pulse when a request is rejected
err_timeout_o  out  1  sticky lock timeout flag
err_lost_o  out  1  sticky loss-of-lock flag

Behaviour:
- Reset values:
  - state IDLE; cfg_ready_o=1; pll_arst_no=0 (the PLL is held in reset until the first configuration).
  - pll_ref_div_o=1, pll_fb_div_o=1.
  - busy_o, locked_o and all error outputs 0; all counters 0; sync flops 0.
- pll_locked_i passes through a 2-flop synchroniser. All lock decisions use the synchronised value.
- cfg_ready_o=1 in IDLE, LOCKED and ERROR, and 0 in RESET and WAIT_LOCK.
- A handshake occurs when cfg_valid_i && cfg_ready_o are high on a rising edge.
- Validation, all unsigned and computed at width max(REF,FB)+7:
  - ref>0 and fb>0
  - ref <= 100*fb
  - 100*ref >= fb
- Invalid request:
  - err_cfg_o pulses for the next cycle.
  - State, divider outputs, pll_arst_no and the sticky flags are unchanged.
- Valid request:
  - Next cycle: state RESET, divider outputs take the new values, and pll_arst_no=0.
  - err_timeout_o and err_lost_o clear.
  - The reset counter loads 0.
- RESET:
  - pll_arst_no stays 0 for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with pll_arst_no=1, and the timeout and stable counters at 0.
- WAIT_LOCK:
  - Synchronised lock high increments the stable counter; lock low clears it.
  - When the stable counter reaches LOCK_STABLE, go to LOCKED.
  - The timeout counter increments every cycle. When it reaches LOCK_TIMEOUT with no lock, go to ERROR with err_timeout_o=1.
  - If stable completes on the same cycle that the timeout expires, lock wins.
- LOCKED:
  - locked_o=1.
  - Synchronised lock low for 1 cycle: err_lost_o=1 and go to ERROR (default behaviour; see Optional Feature).
- ERROR:
  - pll_arst_no stays 1 and the dividers hold their values.
  - The state is left only by a new accepted configuration.
- A new valid request accepted in LOCKED or ERROR restarts the sequence from RESET. locked_o drops the cycle after acceptance.
- Because a request can only be accepted when cfg_ready_o is high, a request cannot pre-empt RESET or WAIT_LOCK; such requests stall.
- rst_i asserted in any state returns all outputs to their reset values on the next edge, including pll_arst_no=0.
- All counters saturate and never wrap.

Optional Feature:
PLL_CFG_CTRL_AUTO_RELOCK_EN:
- Defined: a loss of lock in LOCKED sets err_lost_o=1 and re-enters RESET with the same dividers, instead of going to ERROR.
  - err_lost_o stays set until the next accepted configuration.
  - A subsequent timeout goes to ERROR as normal.
- Undefined: a loss of lock in LOCKED goes to ERROR as described in Behaviour.

Test Plan:
1. Reset release, then request ref=1, fb=10; model locks 40 cycles after arst release -> pll_arst_no low exactly 16 cycles; locked_o high at release+40+2 (sync)+8; pll_fb_div_o=10.
2. Requests ref=0, fb=5, and ref=1, fb=101 -> err_cfg_o one-cycle pulse each; state, dividers and pll_arst_no unchanged.
3. Model never asserts lock -> err_timeout_o=1 exactly 4096 cycles after entering WAIT_LOCK; busy_o=0; cfg_ready_o=1.
4. Lock toggles high 5 cycles, low 1 cycle, then steady high -> stable counter restarts; lock is declared only after 8 consecutive high cycles.
5. In LOCKED, drop lock for 1 cycle -> err_lost_o=1. Macro undefined: state ERROR. Macro defined: pll_arst_no low 16 cycles, then relock to locked_o=1 with the same dividers.
6. Assert rst_i mid-WAIT_LOCK -> next cycle pll_arst_no=0, dividers=1/1, all flags 0, cfg_ready_o=1.
